// File: rtl/ifu_fetch.sv
// Instruction fetch unit: one outstanding memory request, one-entry IR toward decode,
// static JAL-taken prediction, JALR stall until redirect, halt on EBREAK or bus error.
module ifu_fetch #(
  parameter int unsigned          PC_SIZE    = 32,
  parameter int unsigned          INSTR_SIZE = 32,
  parameter logic [PC_SIZE-1:0]   RESET_PC   = PC_SIZE'(32'h8000_0000)
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  ifu_req_valid,
  input  logic                  ifu_req_ready,
  output logic [PC_SIZE-1:0]    ifu_req_addr,
  input  logic                  ifu_rsp_valid,
  output logic                  ifu_rsp_ready,
  input  logic [INSTR_SIZE-1:0] ifu_rsp_instr,
  input  logic                  ifu_rsp_err,
  output logic                  o_ir_valid,
  input  logic                  o_ir_ready,
  output logic [INSTR_SIZE-1:0] o_instr,
  output logic [PC_SIZE-1:0]    o_pc,
  output logic                  o_prdt_taken,
  output logic                  o_err,
  input  logic                  i_redirect_valid,
  input  logic [PC_SIZE-1:0]    i_redirect_pc,
  output logic                  o_halted
);

  localparam logic [6:0]            OPC_JAL  = 7'b1101111;
  localparam logic [6:0]            OPC_JALR = 7'b1100111;
  localparam logic [INSTR_SIZE-1:0] EBREAK   = INSTR_SIZE'(32'h0010_0073);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    HOLD  = 3'd3,
    STALL = 3'd4,
    HALT  = 3'd5
  } state_t;

  state_t                  state, state_nxt;
  logic [PC_SIZE-1:0]      pc_r, pc_nxt;
  logic [PC_SIZE-1:0]      req_addr_nxt;
  logic                    drop_r, drop_nxt;
  logic [INSTR_SIZE-1:0]   instr_nxt;
  logic [PC_SIZE-1:0]      ir_pc_nxt;
  logic                    taken_nxt, err_nxt;
  logic [20:0]             jimm21;
  logic [PC_SIZE-1:0]      jimm;

  // J-type immediate of the incoming word, sign-extended to the pc width
  assign jimm21 = {ifu_rsp_instr[31], ifu_rsp_instr[19:12], ifu_rsp_instr[20],
                   ifu_rsp_instr[30:21], 1'b0};
  assign jimm   = {{(PC_SIZE-21){jimm21[20]}}, jimm21};

  // Next-state and datapath updates; redirect wins over same-cycle events
  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc_r;
    req_addr_nxt = ifu_req_addr;
    drop_nxt     = drop_r;
    instr_nxt    = o_instr;
    ir_pc_nxt    = o_pc;
    taken_nxt    = o_prdt_taken;
    err_nxt      = o_err;
    case (state)
      IDLE: begin
        state_nxt    = REQ;
        req_addr_nxt = pc_r;
      end
      REQ: begin
        if (i_redirect_valid) begin
          pc_nxt   = i_redirect_pc;
          drop_nxt = 1'b1;
        end
        if (ifu_req_ready) state_nxt = WAIT;
      end
      WAIT: begin
        if (i_redirect_valid) begin
          pc_nxt = i_redirect_pc;
          if (ifu_rsp_valid) begin
            drop_nxt     = 1'b0;
            req_addr_nxt = i_redirect_pc;
            state_nxt    = REQ;
          end else begin
            drop_nxt = 1'b1;
          end
        end else if (ifu_rsp_valid) begin
          if (drop_r) begin
            drop_nxt     = 1'b0;
            req_addr_nxt = pc_r;
            state_nxt    = REQ;
          end else begin
            instr_nxt = ifu_rsp_instr;
            ir_pc_nxt = ifu_req_addr;
            err_nxt   = ifu_rsp_err;
            state_nxt = HOLD;
            if (ifu_rsp_instr[6:0] == OPC_JAL) begin
              pc_nxt    = ifu_req_addr + jimm;
              taken_nxt = 1'b1;
            end else begin
              pc_nxt    = ifu_req_addr + PC_SIZE'(4);
              taken_nxt = 1'b0;
            end
          end
        end
      end
      HOLD: begin
        if (i_redirect_valid) begin
          pc_nxt       = i_redirect_pc;
          req_addr_nxt = i_redirect_pc;
          state_nxt    = REQ;
        end else if (o_ir_ready) begin
          if (o_err || (o_instr == EBREAK)) begin
            state_nxt = HALT;
          end else if (o_instr[6:0] == OPC_JALR) begin
            state_nxt = STALL;
          end else begin
            req_addr_nxt = pc_r;
            state_nxt    = REQ;
          end
        end
      end
      STALL: begin
        if (i_redirect_valid) begin
          pc_nxt       = i_redirect_pc;
          req_addr_nxt = i_redirect_pc;
          state_nxt    = REQ;
        end
      end
      HALT:    state_nxt = HALT;
      default: state_nxt = IDLE;
    endcase
  end

  // State, datapath and registered handshake outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      pc_r          <= RESET_PC;
      drop_r        <= 1'b0;
      ifu_req_addr  <= '0;
      o_instr       <= '0;
      o_pc          <= '0;
      o_prdt_taken  <= 1'b0;
      o_err         <= 1'b0;
      ifu_req_valid <= 1'b0;
      ifu_rsp_ready <= 1'b0;
      o_ir_valid    <= 1'b0;
      o_halted      <= 1'b0;
    end else begin
      state         <= state_nxt;
      pc_r          <= pc_nxt;
      drop_r        <= drop_nxt;
      ifu_req_addr  <= req_addr_nxt;
      o_instr       <= instr_nxt;
      o_pc          <= ir_pc_nxt;
      o_prdt_taken  <= taken_nxt;
      o_err         <= err_nxt;
      ifu_req_valid <= (state_nxt == REQ);
      ifu_rsp_ready <= (state_nxt == WAIT);
      o_ir_valid    <= (state_nxt == HOLD);
      o_halted      <= (state_nxt == HALT);
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: a table of straight-line fetches followed by
// hand-written redirect, stall, halt and mid-transaction reset sequences.
module tb_ifu_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid;
  logic        ifu_req_ready;
  logic [31:0] ifu_req_addr;
  logic        ifu_rsp_valid;
  logic        ifu_rsp_ready;
  logic [31:0] ifu_rsp_instr;
  logic        ifu_rsp_err;
  logic        o_ir_valid;
  logic        o_ir_ready;
  logic [31:0] o_instr;
  logic [31:0] o_pc;
  logic        o_prdt_taken;
  logic        o_err;
  logic        i_redirect_valid;
  logic [31:0] i_redirect_pc;
  logic        o_halted;

  int checks   = 0;
  int failures = 0;

  localparam logic [31:0] ADDI   = 32'h0010_0093;
  localparam logic [31:0] JAL_P8 = 32'h0080_006F;
  localparam logic [31:0] JAL_M16 = 32'hFF1F_F06F;
  localparam logic [31:0] JALR   = 32'h0000_8067;
  localparam logic [31:0] EBRK   = 32'h0010_0073;

  ifu_fetch dut (
    .clk              (clk),
    .rst              (rst),
    .ifu_req_valid    (ifu_req_valid),
    .ifu_req_ready    (ifu_req_ready),
    .ifu_req_addr     (ifu_req_addr),
    .ifu_rsp_valid    (ifu_rsp_valid),
    .ifu_rsp_ready    (ifu_rsp_ready),
    .ifu_rsp_instr    (ifu_rsp_instr),
    .ifu_rsp_err      (ifu_rsp_err),
    .o_ir_valid       (o_ir_valid),
    .o_ir_ready       (o_ir_ready),
    .o_instr          (o_instr),
    .o_pc             (o_pc),
    .o_prdt_taken     (o_prdt_taken),
    .o_err            (o_err),
    .i_redirect_valid (i_redirect_valid),
    .i_redirect_pc    (i_redirect_pc),
    .o_halted         (o_halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        err;
    logic        taken;
    int unsigned req_dly;
    int unsigned rsp_dly;
    int unsigned hold_dly;
  } vec_t;

  vec_t vecs[10];

  function automatic vec_t mk(input logic [31:0] pc, input logic [31:0] instr,
                              input logic err, input logic taken,
                              input int unsigned rq, input int unsigned rs,
                              input int unsigned hd);
    vec_t v;
    v.pc = pc; v.instr = instr; v.err = err; v.taken = taken;
    v.req_dly = rq; v.rsp_dly = rs; v.hold_dly = hd;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  // Wait for a request, accept it, respond, check the IR, then consume it
  task automatic fetch_one(input vec_t v);
    int n;
    n = 0;
    while (!ifu_req_valid && n < 20) begin
      step();
      n++;
    end
    chk1("req_valid", ifu_req_valid, 1'b1);
    chk32("req_addr", ifu_req_addr, v.pc);
    ifu_req_ready = 1'b0;
    for (int i = 0; i < int'(v.req_dly); i++) begin
      step();
      chk32("req_addr_stable", ifu_req_addr, v.pc);
    end
    ifu_req_ready = 1'b1;
    step();
    ifu_req_ready = 1'b0;
    chk1("rsp_ready", ifu_rsp_ready, 1'b1);
    for (int i = 0; i < int'(v.rsp_dly); i++) step();
    ifu_rsp_valid = 1'b1;
    ifu_rsp_instr = v.instr;
    ifu_rsp_err   = v.err;
    step();
    ifu_rsp_valid = 1'b0;
    ifu_rsp_err   = 1'b0;
    chk1("ir_valid", o_ir_valid, 1'b1);
    chk32("ir_instr", o_instr, v.instr);
    chk32("ir_pc", o_pc, v.pc);
    chk1("ir_taken", o_prdt_taken, v.taken);
    chk1("ir_err", o_err, v.err);
    for (int i = 0; i < int'(v.hold_dly); i++) begin
      step();
      chk1("hold_valid", o_ir_valid, 1'b1);
      chk32("hold_pc", o_pc, v.pc);
      chk32("hold_instr", o_instr, v.instr);
      chk1("hold_no_req", ifu_req_valid, 1'b0);
    end
    o_ir_ready = 1'b1;
    step();
    o_ir_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = mk(32'h8000_0000, ADDI,    1'b0, 1'b0, 0, 0, 0);
    vecs[1] = mk(32'h8000_0004, ADDI,    1'b0, 1'b0, 2, 0, 0);
    vecs[2] = mk(32'h8000_0008, ADDI,    1'b0, 1'b0, 0, 3, 0);
    vecs[3] = mk(32'h8000_000C, ADDI,    1'b0, 1'b0, 0, 0, 5);
    vecs[4] = mk(32'h8000_0010, JAL_P8,  1'b0, 1'b1, 1, 1, 1);
    vecs[5] = mk(32'h8000_0018, ADDI,    1'b0, 1'b0, 0, 0, 0);
    vecs[6] = mk(32'h8000_001C, ADDI,    1'b0, 1'b0, 0, 2, 0);
    vecs[7] = mk(32'h8000_0020, JAL_M16, 1'b0, 1'b1, 0, 0, 0);
    vecs[8] = mk(32'h8000_0010, JAL_P8,  1'b0, 1'b1, 0, 0, 0);
    vecs[9] = mk(32'h8000_0018, ADDI,    1'b0, 1'b0, 0, 0, 0);

    rst = 1'b0;
    ifu_req_ready = 1'b0; ifu_rsp_valid = 1'b0; ifu_rsp_instr = '0; ifu_rsp_err = 1'b0;
    o_ir_ready = 1'b0; i_redirect_valid = 1'b0; i_redirect_pc = '0;
    repeat (3) step();
    chk1("rst_req_valid", ifu_req_valid, 1'b0);
    chk32("rst_req_addr", ifu_req_addr, 32'h0);
    chk1("rst_rsp_ready", ifu_rsp_ready, 1'b0);
    chk1("rst_ir_valid", o_ir_valid, 1'b0);
    chk32("rst_instr", o_instr, 32'h0);
    chk32("rst_pc", o_pc, 32'h0);
    chk1("rst_taken", o_prdt_taken, 1'b0);
    chk1("rst_err", o_err, 1'b0);
    chk1("rst_halted", o_halted, 1'b0);
    rst = 1'b1;
    step();
    chk1("first_req_latency", ifu_req_valid, 1'b1);
    chk32("first_req_addr", ifu_req_addr, 32'h8000_0000);

    foreach (vecs[i]) fetch_one(vecs[i]);

    // JALR: no request until the execute stage redirects
    fetch_one(mk(32'h8000_001C, ADDI, 1'b0, 1'b0, 0, 0, 0));
    fetch_one(mk(32'h8000_0020, JALR, 1'b0, 1'b0, 0, 0, 0));
    repeat (3) begin
      chk1("stall_no_req", ifu_req_valid, 1'b0);
      step();
    end
    i_redirect_valid = 1'b1; i_redirect_pc = 32'h8000_0100;
    step();
    i_redirect_valid = 1'b0;
    chk1("stall_redir_req", ifu_req_valid, 1'b1);
    fetch_one(mk(32'h8000_0100, ADDI, 1'b0, 1'b0, 0, 0, 0));

    // Redirect while waiting; the late response must be dropped
    chk32("wait_req_addr", ifu_req_addr, 32'h8000_0104);
    ifu_req_ready = 1'b1;
    step();
    ifu_req_ready = 1'b0;
    i_redirect_valid = 1'b1; i_redirect_pc = 32'h8000_0200;
    step();
    i_redirect_valid = 1'b0;
    chk1("wait_drop_ir0", o_ir_valid, 1'b0);
    chk1("wait_drop_noreq", ifu_req_valid, 1'b0);
    step();
    ifu_rsp_valid = 1'b1; ifu_rsp_instr = ADDI;
    step();
    ifu_rsp_valid = 1'b0;
    chk1("wait_drop_ir1", o_ir_valid, 1'b0);
    chk1("wait_drop_req", ifu_req_valid, 1'b1);
    chk32("wait_drop_addr", ifu_req_addr, 32'h8000_0200);
    fetch_one(mk(32'h8000_0200, ADDI, 1'b0, 1'b0, 0, 0, 0));

    // Redirect in HOLD beats a same-cycle consume; target wraps past 2^32
    ifu_req_ready = 1'b1;
    step();
    ifu_req_ready = 1'b0;
    ifu_rsp_valid = 1'b1; ifu_rsp_instr = ADDI;
    step();
    ifu_rsp_valid = 1'b0;
    chk1("hold_redir_ir", o_ir_valid, 1'b1);
    chk32("hold_redir_pc", o_pc, 32'h8000_0204);
    o_ir_ready = 1'b1; i_redirect_valid = 1'b1; i_redirect_pc = 32'hFFFF_FFFC;
    step();
    o_ir_ready = 1'b0; i_redirect_valid = 1'b0;
    chk1("hold_redir_inval", o_ir_valid, 1'b0);
    chk1("hold_redir_req", ifu_req_valid, 1'b1);
    chk32("hold_redir_addr", ifu_req_addr, 32'hFFFF_FFFC);
    fetch_one(mk(32'hFFFF_FFFC, ADDI, 1'b0, 1'b0, 0, 0, 0));
    fetch_one(mk(32'h0000_0000, ADDI, 1'b0, 1'b0, 0, 0, 0));

    // Redirect while the request is still pending: old address completes, word dropped
    chk32("req_redir_pre", ifu_req_addr, 32'h0000_0004);
    i_redirect_valid = 1'b1; i_redirect_pc = 32'h8000_0300;
    step();
    i_redirect_valid = 1'b0;
    chk1("req_redir_valid", ifu_req_valid, 1'b1);
    chk32("req_redir_old_addr", ifu_req_addr, 32'h0000_0004);
    ifu_req_ready = 1'b1;
    step();
    ifu_req_ready = 1'b0;
    ifu_rsp_valid = 1'b1; ifu_rsp_instr = ADDI;
    step();
    ifu_rsp_valid = 1'b0;
    chk1("req_redir_ir", o_ir_valid, 1'b0);
    chk32("req_redir_addr", ifu_req_addr, 32'h8000_0300);

    // EBREAK halts; redirects are ignored afterwards
    fetch_one(mk(32'h8000_0300, EBRK, 1'b0, 1'b0, 0, 0, 0));
    chk1("ebrk_halted", o_halted, 1'b1);
    chk1("ebrk_no_req", ifu_req_valid, 1'b0);
    i_redirect_valid = 1'b1; i_redirect_pc = 32'h8000_0400;
    step();
    i_redirect_valid = 1'b0;
    repeat (3) begin
      chk1("halt_still", o_halted, 1'b1);
      chk1("halt_no_req", ifu_req_valid, 1'b0);
      step();
    end

    // Reset mid-transaction, with a stale response arriving after release
    rst = 1'b0;
    step();
    rst = 1'b1;
    step();
    ifu_req_ready = 1'b1;
    step();
    ifu_req_ready = 1'b0;
    chk1("mid_wait", ifu_rsp_ready, 1'b1);
    rst = 1'b0;
    step();
    chk1("mid_rst_req", ifu_req_valid, 1'b0);
    chk1("mid_rst_rsp_ready", ifu_rsp_ready, 1'b0);
    chk1("mid_rst_halted", o_halted, 1'b0);
    chk32("mid_rst_addr", ifu_req_addr, 32'h0);
    rst = 1'b1;
    ifu_rsp_valid = 1'b1; ifu_rsp_instr = ADDI;
    step();
    chk1("stale_rsp_ready", ifu_rsp_ready, 1'b0);
    step();
    ifu_rsp_valid = 1'b0;
    chk1("stale_ir", o_ir_valid, 1'b0);

    // Bus error: IR carries o_err, halt after the handshake
    fetch_one(mk(32'h8000_0000, ADDI, 1'b1, 1'b0, 0, 0, 0));
    chk1("err_halted", o_halted, 1'b1);
    chk1("err_no_req", ifu_req_valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
Instruction fetch unit feeding exu_decode. Issues one instruction-memory request at a time and captures the response into a one-entry instruction register (IR). Presents the IR to decode as rv32 instr, pc and prdt_taken over a valid/ready handshake. Applies static JAL-taken prediction, stalls on JALR until the execute stage redirects, and stops on EBREAK or a bus error.

Parameters:
PC_SIZE, 32, width of pc/address
INSTR_SIZE, 32, instruction width
RESET_PC, 32'h8000_0000, first fetch address after reset

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-low reset
ifu_req_valid  out  1  memory request valid
ifu_req_ready  in  1  memory accepts request
ifu_req_addr  out  PC_SIZE  fetch address
ifu_rsp_valid  in  1  memory response valid
ifu_rsp_ready  out  1  fetch accepts response
ifu_rsp_instr  in  INSTR_SIZE  fetched word
ifu_rsp_err  in  1  bus error with response
o_ir_valid  out  1  IR holds instruction for decode
o_ir_ready  in  1  decode consumes IR
o_instr  out  INSTR_SIZE  to decode rv32_instr
o_pc  out  PC_SIZE  to decode i_pc
o_prdt_taken  out  1  to decode i_prdt_taken
o_err  out  1  IR word came with bus error
i_redirect_valid  in  1  execute redirect (jalr target / mispredict)
i_redirect_pc  in  PC_SIZE  redirect target
o_halted  out  1  fetch stopped (ebreak or error)

Behaviour:
- Reset (rst=0 at posedge): state=IDLE; pc_r=RESET_PC; drop_r=0. All outputs are 0, including o_instr, o_pc and ifu_req_addr.
- States: IDLE, REQ, WAIT, HOLD, STALL, HALT.
- IDLE: always goes to REQ next cycle; req_addr_r<=pc_r. The first request is therefore visible 1 cycle after reset release.
- REQ: ifu_req_valid=1, ifu_req_addr=req_addr_r. The address is held stable while valid&!ready. On ifu_req_ready, go to WAIT.
- WAIT: ifu_rsp_ready=1 (0 in every other state). On ifu_rsp_valid:
  - If drop_r=1: discard the word, clear drop_r, req_addr_r<=pc_r, go to REQ.
  - Otherwise: o_instr<=ifu_rsp_instr, o_pc<=req_addr_r, o_err<=ifu_rsp_err, go to HOLD.
  - Next-pc: if opcode==7'b1101111 (JAL), pc_r<=req_addr_r + J-imm (sign-extended, bit0=0) and o_prdt_taken<=1. Else pc_r<=req_addr_r+4 and o_prdt_taken<=0. Addition wraps mod 2^PC_SIZE.
- HOLD: o_ir_valid=1; IR fields remain stable until the handshake. On o_ir_ready:
  - If o_err=1, go to HALT.
  - Else if o_instr==32'h0010_0073 (EBREAK), go to HALT.
  - Else if opcode==7'b1100111 (JALR), go to STALL.
  - Else req_addr_r<=pc_r and go to REQ.
- STALL: no requests. Wait for i_redirect_valid.
- HALT: o_halted=1. Absorbing until reset; redirects are ignored.
- Redirect (i_redirect_valid=1) has priority over all same-cycle events in every state except IDLE and HALT. In all cases pc_r<=i_redirect_pc, then per state:
  - REQ, req_ready=0: the pending request completes at the old address (no withdrawal) with drop_r<=1.
  - REQ, req_ready=1: go to WAIT with drop_r<=1.
  - WAIT, no rsp_valid: drop_r<=1.
  - WAIT with rsp_valid the same cycle: the word is discarded, req_addr_r<=i_redirect_pc, go to REQ.
  - HOLD: IR invalidated (o_ir_valid=0 next cycle) even if o_ir_ready=1 the same cycle, req_addr_r<=i_redirect_pc, go to REQ.
  - STALL: req_addr_r<=i_redirect_pc, go to REQ.
- At most one outstanding memory request. Best-case throughput is one instruction per 3 cycles (REQ→WAIT→HOLD) with zero-latency memory.
- Reset asserted mid-transaction: state returns to IDLE immediately. Any in-flight response arriving after reset is ignored because ifu_rsp_ready=0 in IDLE/REQ.

Test Plan:
- Reset release, RESET_PC=0x80000000, memory always ready, returns 0x00100093 (addi) → first req_valid 1 cycle after release at 0x80000000; IR pc=0x80000000, prdt_taken=0; next req 0x80000004.
- Word 0x0080006F (jal x0,+8) at 0x80000010 → o_prdt_taken=1; next ifu_req_addr=0x80000018.
- Word 0x00008067 (jalr) at 0x80000020 → no request after handshake; i_redirect_pc=0x80000100 → next request 0x80000100.
- Redirect to 0x80000200 while in WAIT, response arriving 2 cycles later → that response is not presented (o_ir_valid stays 0); next request 0x80000200.
- o_ir_ready=0 for 5 cycles in HOLD → o_instr/o_pc stable, no new request; consumed on ready, fetch resumes.
- Word 0x00100073 consumed → o_halted=1, no further requests, redirect ignored. Separately, rsp_err=1 → o_err=1 in IR, then halted after the handshake.
